// File: rtl/y_median3x3_filter.sv
// Streaming 3x3 median filter on the luma channel.
// Two line buffers feed a 3x3 window. A pipelined sorting network then
// produces the median. Border windows pass the current pixel through
// unchanged. Every signal sees the same fixed 4-clock latency.
`timescale 1ns/1ps
module y_median3x3_filter #(
    parameter int IMG_HDISP = 640,
    parameter int ROW_W     = 11,
    parameter int COL_W     = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y
);

    localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};
    localparam logic [ROW_W-1:0] ROW_MAX = {ROW_W{1'b1}};

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic en;
    assign en = per_frame_clken & per_frame_href;

    logic [7:0]       lb1_q [IMG_HDISP];
    logic [7:0]       lb1_d [IMG_HDISP];
    logic [7:0]       lb2_q [IMG_HDISP];
    logic [7:0]       lb2_d [IMG_HDISP];
    logic [7:0]       win_q [3][3];
    logic [7:0]       win_d [3][3];
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic             ok_s1_q, ok_s1_d;
    logic [7:0]       rmin_q [3];
    logic [7:0]       rmin_d [3];
    logic [7:0]       rmid_q [3];
    logic [7:0]       rmid_d [3];
    logic [7:0]       rmax_q [3];
    logic [7:0]       rmax_d [3];
    logic             ok_s2_q, ok_s2_d;
    logic [7:0]       pt_s2_q, pt_s2_d;
    logic [7:0]       a_s3_q, a_s3_d, b_s3_q, b_s3_d, c_s3_q, c_s3_d;
    logic             ok_s3_q, ok_s3_d;
    logic [7:0]       pt_s3_q, pt_s3_d;
    logic [7:0]       y_s4_q, y_s4_d;
    logic [3:0]       vs_dly_q, vs_dly_d;
    logic [3:0]       hr_dly_q, hr_dly_d;
    logic [3:0]       ck_dly_q, ck_dly_d;

    // Line buffers and window shift together on each valid pixel.
    always_comb begin
        lb1_d = lb1_q;
        lb2_d = lb2_q;
        win_d = win_q;
        if (en) begin
            for (int i = IMG_HDISP - 1; i > 0; i--) begin
                lb1_d[i] = lb1_q[i-1];
                lb2_d[i] = lb2_q[i-1];
            end
            lb1_d[0] = per_img_Y;
            lb2_d[0] = lb1_q[IMG_HDISP-1];
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_q[IMG_HDISP-1];
            win_d[1][2] = lb1_q[IMG_HDISP-1];
            win_d[2][2] = per_img_Y;
        end
    end

    // Position counters and the border flag sampled with the window load.
    always_comb begin
        vsync_d   = per_frame_vsync;
        href_d    = per_frame_href;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        ok_s1_d   = ok_s1_q;
        if (!per_frame_href)
            col_cnt_d = '0;
        else if (en && col_cnt_q != COL_MAX)
            col_cnt_d = col_cnt_q + 1'b1;
        // A frame start overrides a line end landing in the same cycle.
        if (per_frame_vsync && !vsync_q)
            row_cnt_d = '0;
        else if (href_q && !per_frame_href && row_cnt_q != ROW_MAX)
            row_cnt_d = row_cnt_q + 1'b1;
        if (en)
            ok_s1_d = (col_cnt_q >= COL_W'(2)) && (row_cnt_q >= ROW_W'(2));
    end

    // Median network S2..S4 plus the 4-deep sync delay lines.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rmin_d[r] = min2(min2(win_q[r][0], win_q[r][1]), win_q[r][2]);
            rmid_d[r] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
            rmax_d[r] = max2(max2(win_q[r][0], win_q[r][1]), win_q[r][2]);
        end
        ok_s2_d  = ok_s1_q;
        pt_s2_d  = win_q[2][2];
        a_s3_d   = max2(max2(rmin_q[0], rmin_q[1]), rmin_q[2]);
        b_s3_d   = med3(rmid_q[0], rmid_q[1], rmid_q[2]);
        c_s3_d   = min2(min2(rmax_q[0], rmax_q[1]), rmax_q[2]);
        ok_s3_d  = ok_s2_q;
        pt_s3_d  = pt_s2_q;
        y_s4_d   = ok_s3_q ? med3(a_s3_q, b_s3_q, c_s3_q) : pt_s3_q;
        vs_dly_d = {vs_dly_q[2:0], per_frame_vsync};
        hr_dly_d = {hr_dly_q[2:0], per_frame_href};
        ck_dly_d = {ck_dly_q[2:0], per_frame_clken};
    end

    // All state registers; everything clears on reset, including buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_HDISP; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
                rmin_q[r] <= '0;
                rmid_q[r] <= '0;
                rmax_q[r] <= '0;
            end
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            ok_s1_q   <= 1'b0;
            ok_s2_q   <= 1'b0;
            pt_s2_q   <= '0;
            a_s3_q    <= '0;
            b_s3_q    <= '0;
            c_s3_q    <= '0;
            ok_s3_q   <= 1'b0;
            pt_s3_q   <= '0;
            y_s4_q    <= '0;
            vs_dly_q  <= '0;
            hr_dly_q  <= '0;
            ck_dly_q  <= '0;
        end else begin
            lb1_q     <= lb1_d;
            lb2_q     <= lb2_d;
            win_q     <= win_d;
            rmin_q    <= rmin_d;
            rmid_q    <= rmid_d;
            rmax_q    <= rmax_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            ok_s1_q   <= ok_s1_d;
            ok_s2_q   <= ok_s2_d;
            pt_s2_q   <= pt_s2_d;
            a_s3_q    <= a_s3_d;
            b_s3_q    <= b_s3_d;
            c_s3_q    <= c_s3_d;
            ok_s3_q   <= ok_s3_d;
            pt_s3_q   <= pt_s3_d;
            y_s4_q    <= y_s4_d;
            vs_dly_q  <= vs_dly_d;
            hr_dly_q  <= hr_dly_d;
            ck_dly_q  <= ck_dly_d;
        end
    end

    assign post_frame_vsync = vs_dly_q[3];
    assign post_frame_href  = hr_dly_q[3];
    assign post_frame_clken = ck_dly_q[3];
    assign post_img_Y       = post_frame_href ? y_s4_q : 8'd0;

endmodule

// File: tb/tb_y_median3x3_filter.sv
// Directed bench for y_median3x3_filter with an 8-pixel line length.
`timescale 1ns/1ps
module tb_y_median3x3_filter;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y = 8'd0;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_Y;

    y_median3x3_filter #(.IMG_HDISP(W), .ROW_W(11), .COL_W(11)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         first_in = -1;
    int         first_out = -1;
    logic       prev_ph = 1'b0;
    logic [7:0] img [0:5][0:7];
    int         cap [$];

    always @(posedge clk) cyc++;

    // Collect every valid output pixel and note the first output line start.
    always @(negedge clk) begin
        if (post_frame_clken) cap.push_back(int'(post_img_Y));
        if (post_frame_href && !prev_ph && first_out < 0) first_out = cyc;
        prev_ph = post_frame_href;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_pix(input int r, input int c);
        int v [9];
        int k, t;
        if (r < 2 || c < 2) return int'(img[r][c]);
        k = 0;
        for (int i = r - 2; i <= r; i++)
            for (int j = c - 2; j <= c; j++) begin
                v[k] = int'(img[i][j]);
                k++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    task automatic set_ramp();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(r * 16 + c);
    endtask

    task automatic set_flat(input logic [7:0] v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < W; c++) img[r][c] = v;
    endtask

    // Drives one frame; rst_row >= 0 pulses reset mid-line and abandons the frame.
    task automatic drive_frame(input int nrows, input bit gaps, input int rst_row);
        int c, k;
        per_frame_vsync = 1'b1;
        repeat (2) @(negedge clk);
        per_frame_vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int r = 0; r < nrows; r++) begin
            per_frame_href = 1'b1;
            c = 0;
            k = 0;
            while (c < W) begin
                if (r == rst_row && c == 4) begin
                    rst_n = 1'b0;
                    per_frame_href = 1'b0;
                    per_frame_clken = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                per_frame_clken = (!gaps || (k % 3 == 0));
                per_img_Y = per_frame_clken ? img[r][c] : 8'hEE;
                if (first_in < 0) first_in = cyc;
                @(negedge clk);
                if (per_frame_clken) c++;
                k++;
            end
            per_frame_href = 1'b0;
            per_frame_clken = 1'b0;
            per_img_Y = 8'd0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic check_frame(input int nrows, input string name);
        int obs;
        repeat (8) begin
            @(negedge clk);
            if (!post_frame_href) check({name, "_mask"}, int'(post_img_Y), 0);
        end
        check({name, "_count"}, cap.size(), nrows * W);
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < W; c++) begin
                obs = (cap.size() > 0) ? cap.pop_front() : -1;
                check($sformatf("%s_r%0d_c%0d", name, r, c), obs, exp_pix(r, c));
            end
        cap.delete();
    endtask

    initial begin
        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            per_frame_vsync = 1'($urandom_range(0, 1));
            per_frame_href  = 1'($urandom_range(0, 1));
            per_frame_clken = 1'($urandom_range(0, 1));
            per_img_Y       = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("rst_vsync", int'(post_frame_vsync), 0);
            check("rst_href", int'(post_frame_href), 0);
            check("rst_clken", int'(post_frame_clken), 0);
            check("rst_y", int'(post_img_Y), 0);
        end
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Y       = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cap.delete();

        // 4-line ramp frame with href latency check.
        set_ramp();
        drive_frame(4, 1'b0, -1);
        check("href_latency", first_out - first_in, 4);
        check_frame(4, "ramp4");

        set_flat(8'd100);
        drive_frame(6, 1'b0, -1);
        check_frame(6, "flat");

        set_flat(8'd0);
        img[3][4] = 8'd255;
        drive_frame(6, 1'b0, -1);
        check_frame(6, "impulse");

        set_ramp();
        drive_frame(6, 1'b0, -1);
        check_frame(6, "ramp");

        drive_frame(6, 1'b1, -1);
        check_frame(6, "gaps");

        // Reset during line 3, then a fresh frame.
        drive_frame(6, 1'b0, 3);
        check("midrst_clken", int'(post_frame_clken), 0);
        check("midrst_y", int'(post_img_Y), 0);
        repeat (4) @(negedge clk);
        cap.delete();
        drive_frame(6, 1'b0, -1);
        check_frame(6, "after_rst");

        // Back-to-back frames: row count must restart on the second one.
        drive_frame(6, 1'b0, -1);
        check_frame(6, "b2b_1");
        drive_frame(6, 1'b0, -1);
        check_frame(6, "b2b_2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
